// File: rtl/hdmi_ycbcr422_packer_pkg.sv
// Shared constants and types for the HDMI YCbCr 4:2:2 output path.
// HDMI_CHROMA_AVG_EN selects the averaging chroma decimator, which adds one pipeline stage.
package hdmi_ycbcr422_packer_pkg;

  // BT.601 limited-range matrix, scaled by 256
  localparam int COEF_Y_R  = 66;
  localparam int COEF_Y_G  = 129;
  localparam int COEF_Y_B  = 25;
  localparam int COEF_CB_R = -38;
  localparam int COEF_CB_G = -74;
  localparam int COEF_CB_B = 112;
  localparam int COEF_CR_R = 112;
  localparam int COEF_CR_G = -94;
  localparam int COEF_CR_B = -18;

  localparam int ROUND = 128;
  localparam int SHIFT = 8;
  localparam int Y_OFS = 16;
  localparam int C_OFS = 128;

  localparam int Y_MIN = 16;
  localparam int Y_MAX = 235;
  localparam int C_MIN = 16;
  localparam int C_MAX = 240;

  localparam logic [7:0] BLANK_Y_DEF = 8'h10;
  localparam logic [7:0] BLANK_C_DEF = 8'h80;

  localparam int unsigned MAC_LAT = 3;
`ifdef HDMI_CHROMA_AVG_EN
  localparam int unsigned LAT = MAC_LAT + 2;
`else
  localparam int unsigned LAT = MAC_LAT + 1;
`endif

  typedef enum logic {
    PhEven = 1'b0,
    PhOdd  = 1'b1
  } phase_e;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

endpackage

// File: rtl/rgb2ycbcr_mac.sv
// RGB to BT.601 limited-range YCbCr: products, sums, then round/offset/clamp.
// Three-cycle latency, no control logic.
module rgb2ycbcr_mac
  import hdmi_ycbcr422_packer_pkg::*;
#(
  parameter int unsigned COLOR_W = 8
) (
  input  logic               clk_pix,
  input  logic               rst_n,
  input  logic [COLOR_W-1:0] r,
  input  logic [COLOR_W-1:0] g,
  input  logic [COLOR_W-1:0] b,
  output logic [COLOR_W-1:0] y,
  output logic [COLOR_W-1:0] cb,
  output logic [COLOR_W-1:0] cr
);

  localparam int unsigned AccW = COLOR_W + 10;
  typedef logic signed [AccW-1:0] acc_t;

  acc_t               r_s, g_s, b_s;
  acc_t               prod_d [9];
  acc_t               prod_q [9];
  acc_t               sum_d  [3];
  acc_t               sum_q  [3];
  logic [COLOR_W-1:0] y_d, cb_d, cr_d;
  logic [COLOR_W-1:0] y_q, cb_q, cr_q;

  // Round-to-nearest, add the range offset, then saturate into the legal code range.
  function automatic logic [COLOR_W-1:0] scale_clamp(input acc_t sum, input int ofs,
                                                     input int lo, input int hi);
    acc_t v;
    v = ((sum + acc_t'(ROUND)) >>> SHIFT) + acc_t'(ofs);
    if (v < acc_t'(lo)) return COLOR_W'(lo);
    if (v > acc_t'(hi)) return COLOR_W'(hi);
    return v[COLOR_W-1:0];
  endfunction

  assign r_s = acc_t'(r);
  assign g_s = acc_t'(g);
  assign b_s = acc_t'(b);

  always_comb begin
    prod_d[0] = r_s * acc_t'(COEF_Y_R);
    prod_d[1] = g_s * acc_t'(COEF_Y_G);
    prod_d[2] = b_s * acc_t'(COEF_Y_B);
    prod_d[3] = r_s * acc_t'(COEF_CB_R);
    prod_d[4] = g_s * acc_t'(COEF_CB_G);
    prod_d[5] = b_s * acc_t'(COEF_CB_B);
    prod_d[6] = r_s * acc_t'(COEF_CR_R);
    prod_d[7] = g_s * acc_t'(COEF_CR_G);
    prod_d[8] = b_s * acc_t'(COEF_CR_B);
  end

  always_comb begin
    sum_d[0] = prod_q[0] + prod_q[1] + prod_q[2];
    sum_d[1] = prod_q[3] + prod_q[4] + prod_q[5];
    sum_d[2] = prod_q[6] + prod_q[7] + prod_q[8];
  end

  always_comb begin
    y_d  = scale_clamp(sum_q[0], Y_OFS, Y_MIN, Y_MAX);
    cb_d = scale_clamp(sum_q[1], C_OFS, C_MIN, C_MAX);
    cr_d = scale_clamp(sum_q[2], C_OFS, C_MIN, C_MAX);
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
      for (int i = 0; i < 3; i++) sum_q[i] <= '0;
      y_q  <= COLOR_W'(BLANK_Y_DEF);
      cb_q <= COLOR_W'(BLANK_C_DEF);
      cr_q <= COLOR_W'(BLANK_C_DEF);
    end else begin
      for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
      for (int i = 0; i < 3; i++) sum_q[i] <= sum_d[i];
      y_q  <= y_d;
      cb_q <= cb_d;
      cr_q <= cr_d;
    end
  end

  assign y  = y_q;
  assign cb = cb_q;
  assign cr = cr_q;

endmodule

// File: rtl/hdmi_ycbcr422_packer.sv
// RGB to YCbCr 4:2:2 packer driving the ADV7511 pins, with delay-matched syncs.
// Define HDMI_CHROMA_AVG_EN to average chroma over each pixel pair (adds one stage).
module hdmi_ycbcr422_packer
  import hdmi_ycbcr422_packer_pkg::*;
#(
  parameter int unsigned        COLOR_W  = 8,
  parameter logic [COLOR_W-1:0] BLANK_Y  = COLOR_W'(BLANK_Y_DEF),
  parameter logic [COLOR_W-1:0] BLANK_C  = COLOR_W'(BLANK_C_DEF),
  parameter bit                 CB_FIRST = 1'b1
) (
  input  logic                 clk_pix,
  input  logic                 rst_n,
  input  logic                 vid_de,
  input  logic                 vid_hs,
  input  logic                 vid_vs,
  input  logic [COLOR_W-1:0]   vid_r,
  input  logic [COLOR_W-1:0]   vid_g,
  input  logic [COLOR_W-1:0]   vid_b,
  output logic [2*COLOR_W-1:0] hdmi_d,
  output logic                 hdmi_de,
  output logic                 hdmi_hsync,
  output logic                 hdmi_vsync
);

  sync_t                ctl_q [LAT];
  logic [COLOR_W-1:0]   y3, cb3, cr3;
  logic [COLOR_W-1:0]   c_a3, c_b3;
  logic                 de3;
  phase_e               phase_q, phase_d;
  logic [COLOR_W-1:0]   c_hold_q, c_hold_d;
  logic [2*COLOR_W-1:0] d_q, d_d;

  rgb2ycbcr_mac #(
    .COLOR_W (COLOR_W)
  ) u_mac (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .r       (vid_r),
    .g       (vid_g),
    .b       (vid_b),
    .y       (y3),
    .cb      (cb3),
    .cr      (cr3)
  );

  assign de3  = ctl_q[MAC_LAT-1].de;
  assign c_a3 = CB_FIRST ? cb3 : cr3;
  assign c_b3 = CB_FIRST ? cr3 : cb3;

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LAT; i++) ctl_q[i] <= '0;
    end else begin
      ctl_q[0] <= '{de: vid_de, hs: vid_hs, vs: vid_vs};
      for (int unsigned i = 1; i < LAT; i++) ctl_q[i] <= ctl_q[i-1];
    end
  end

  // Phase belongs to the pixel leaving the matrix; any blank cycle restarts a line at even.
  always_comb begin
    phase_d = PhEven;
    if (de3) phase_d = (phase_q == PhEven) ? PhOdd : PhEven;
  end

`ifdef HDMI_CHROMA_AVG_EN
  logic [COLOR_W-1:0] y4_q, c_a4_q, c_b4_q;
  phase_e             phase4_q;
  logic               de4;

  assign de4 = ctl_q[MAC_LAT].de;

  function automatic logic [COLOR_W-1:0] avg2(input logic [COLOR_W-1:0] a,
                                              input logic [COLOR_W-1:0] b);
    logic [COLOR_W:0] s;
    s = {1'b0, a} + {1'b0, b} + {{COLOR_W{1'b0}}, 1'b1};
    return s[COLOR_W:1];
  endfunction

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      y4_q     <= BLANK_Y;
      c_a4_q   <= BLANK_C;
      c_b4_q   <= BLANK_C;
      phase4_q <= PhEven;
    end else begin
      y4_q     <= y3;
      c_a4_q   <= c_a3;
      c_b4_q   <= c_b3;
      phase4_q <= phase_q;
    end
  end

  // An even pixel pairs with the one now leaving the matrix; if that slot is blank it stands alone.
  always_comb begin
    d_d      = {BLANK_Y, BLANK_C};
    c_hold_d = c_hold_q;
    if (de4) begin
      if (phase4_q == PhOdd) begin
        d_d = {y4_q, c_hold_q};
      end else if (de3) begin
        d_d      = {y4_q, avg2(c_a4_q, c_a3)};
        c_hold_d = avg2(c_b4_q, c_b3);
      end else begin
        d_d = {y4_q, c_a4_q};
      end
    end
  end
`else
  // Co-sited: the even pixel's second chroma sample is held for the odd slot.
  always_comb begin
    d_d      = {BLANK_Y, BLANK_C};
    c_hold_d = c_hold_q;
    if (de3) begin
      if (phase_q == PhEven) begin
        d_d      = {y3, c_a3};
        c_hold_d = c_b3;
      end else begin
        d_d = {y3, c_hold_q};
      end
    end
  end
`endif

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PhEven;
      c_hold_q <= BLANK_C;
      d_q      <= {BLANK_Y, BLANK_C};
    end else begin
      phase_q  <= phase_d;
      c_hold_q <= c_hold_d;
      d_q      <= d_d;
    end
  end

  assign hdmi_d     = d_q;
  assign hdmi_de    = ctl_q[LAT-1].de;
  assign hdmi_hsync = ctl_q[LAT-1].hs;
  assign hdmi_vsync = ctl_q[LAT-1].vs;

endmodule

// File: tb/tb_hdmi_ycbcr422_packer.sv
// Self-checking bench for hdmi_ycbcr422_packer against a pixel-stream reference model.
// Honours HDMI_CHROMA_AVG_EN for latency and chroma expectations.
module tb_hdmi_ycbcr422_packer;

`ifdef HDMI_CHROMA_AVG_EN
  localparam int LAT = 5;
  localparam bit AVG = 1'b1;
`else
  localparam int LAT = 4;
  localparam bit AVG = 1'b0;
`endif
  localparam logic [15:0] BLANK = 16'h1080;

  logic        clk_pix = 1'b0;
  logic        rst_n;
  logic        vid_de, vid_hs, vid_vs;
  logic [7:0]  vid_r, vid_g, vid_b;
  logic [15:0] hdmi_d;
  logic        hdmi_de, hdmi_hsync, hdmi_vsync;

  always #5 clk_pix = ~clk_pix;

  hdmi_ycbcr422_packer dut (
    .clk_pix    (clk_pix),
    .rst_n      (rst_n),
    .vid_de     (vid_de),
    .vid_hs     (vid_hs),
    .vid_vs     (vid_vs),
    .vid_r      (vid_r),
    .vid_g      (vid_g),
    .vid_b      (vid_b),
    .hdmi_d     (hdmi_d),
    .hdmi_de    (hdmi_de),
    .hdmi_hsync (hdmi_hsync),
    .hdmi_vsync (hdmi_vsync)
  );

  typedef struct {
    logic       de, hs, vs;
    logic [7:0] r, g, b;
  } pix_t;

  pix_t        stim[$];
  logic [15:0] exp_d[$];
  logic [15:0] obs_d[$];
  logic        obs_de[$], obs_hs[$], obs_vs[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  function automatic pix_t px(input logic de, input logic hs, input logic vs,
                              input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    pix_t p;
    p.de = de; p.hs = hs; p.vs = vs; p.r = r; p.g = g; p.b = b;
    return p;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // BT.601 limited range straight from the matrix definition.
  function automatic void ycc(input pix_t p, output int y, output int cb, output int cr);
    int r, g, b;
    r = p.r; g = p.g; b = p.b;
    y  = clampi(16  + ((66 * r + 129 * g + 25 * b + 128) >>> 8), 16, 235);
    cb = clampi(128 + ((-38 * r - 74 * g + 112 * b + 128) >>> 8), 16, 240);
    cr = clampi(128 + ((112 * r - 94 * g - 18 * b + 128) >>> 8), 16, 240);
  endfunction

  function automatic logic [7:0] rnd_c();
    case ($urandom_range(0, 7))
      0:       return 8'd0;
      1:       return 8'd255;
      default: return 8'($urandom);
    endcase
  endfunction

  // Walk each DE run: even position carries Cb, odd position carries Cr of the pair.
  function automatic void build_expected();
    int y, cb, cr, yo, cbo, cro, c, k;
    exp_d.delete();
    k = 0;
    for (int t = 0; t < stim.size(); t++) begin
      if (!stim[t].de) begin
        exp_d.push_back(BLANK);
        k = 0;
      end else begin
        ycc(stim[t], y, cb, cr);
        if (k % 2 == 0) begin
          c = cb;
          if (AVG && (t + 1 < stim.size()) && stim[t+1].de) begin
            ycc(stim[t+1], yo, cbo, cro);
            c = (cb + cbo + 1) / 2;
          end
        end else begin
          ycc(stim[t-1], yo, cbo, cro);
          c = AVG ? (cro + cr + 1) / 2 : cro;
        end
        exp_d.push_back({8'(y), 8'(c)});
        k++;
      end
    end
  endfunction

  task automatic drive(input pix_t p);
    vid_de = p.de; vid_hs = p.hs; vid_vs = p.vs;
    vid_r = p.r; vid_g = p.g; vid_b = p.b;
  endtask

  // Plays stim; obs[i + LAT] is the output that belongs to stim[i].
  task automatic run_stim();
    obs_d.delete(); obs_de.delete(); obs_hs.delete(); obs_vs.delete();
    for (int i = 0; i < stim.size() + LAT + 1; i++) begin
      @(negedge clk_pix);
      obs_d.push_back(hdmi_d);
      obs_de.push_back(hdmi_de);
      obs_hs.push_back(hdmi_hsync);
      obs_vs.push_back(hdmi_vsync);
      if (i < stim.size()) drive(stim[i]);
      else drive(px(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
    end
    build_expected();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(px(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
    repeat (3) @(negedge clk_pix);
    tests_run += 4;
    if (hdmi_d !== BLANK) begin
      tests_failed++; $display("FAIL reset_d: got %h want %h", hdmi_d, BLANK);
    end
    if (hdmi_de !== 1'b0) begin
      tests_failed++; $display("FAIL reset_de: got %b want 0", hdmi_de);
    end
    if (hdmi_hsync !== 1'b0) begin
      tests_failed++; $display("FAIL reset_hs: got %b want 0", hdmi_hsync);
    end
    if (hdmi_vsync !== 1'b0) begin
      tests_failed++; $display("FAIL reset_vs: got %b want 0", hdmi_vsync);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 'h123; i++) begin
      @(negedge clk_pix);
      drive(px(1'b1, 1'b1, 1'b1, rnd_c(), rnd_c(), rnd_c()));
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run += 4;
    if (hdmi_d !== BLANK) begin
      tests_failed++; $display("FAIL midline_reset_d: got %h want %h", hdmi_d, BLANK);
    end
    if (hdmi_de !== 1'b0) begin
      tests_failed++; $display("FAIL midline_reset_de: got %b want 0", hdmi_de);
    end
    if (hdmi_hsync !== 1'b0) begin
      tests_failed++; $display("FAIL midline_reset_hs: got %b want 0", hdmi_hsync);
    end
    if (hdmi_vsync !== 1'b0) begin
      tests_failed++; $display("FAIL midline_reset_vs: got %b want 0", hdmi_vsync);
    end
    drive(px(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
    repeat (2) @(negedge clk_pix);
    rst_n = 1'b1;
    stim.delete();
    stim.push_back(px(1'b1, 1'b0, 1'b0, 8'd255, 8'd0, 8'd0));
    stim.push_back(px(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd255));
    stim.push_back(px(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
    run_stim();
    for (int i = 0; i < LAT; i++) begin
      tests_run++;
      if (obs_de[i] !== 1'b0 || obs_d[i] !== BLANK) begin
        tests_failed++;
        $display("FAIL post_reset_flush[%0d]: got de=%b d=%h want de=0 d=%h",
                 i, obs_de[i], obs_d[i], BLANK);
      end
    end
    tests_run++;
    if (obs_de[LAT] !== 1'b1 || obs_d[LAT] !== exp_d[0]) begin
      tests_failed++;
      $display("FAIL post_reset_first_pixel: got de=%b d=%h want de=1 d=%h",
               obs_de[LAT], obs_d[LAT], exp_d[0]);
    end
  endtask

  task automatic test_colors();
    logic [15:0] want [9];
    want = '{16'hEB80, 16'hEB80, BLANK, 16'h1080, 16'h1080, BLANK,
             16'h525A, 16'h52F0, BLANK};
    stim.delete();
    stim.push_back(px(1'b1, 1'b0, 1'b0, 8'd255, 8'd255, 8'd255));
    stim.push_back(px(1'b1, 1'b0, 1'b0, 8'd255, 8'd255, 8'd255));
    stim.push_back(px(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
    stim.push_back(px(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
    stim.push_back(px(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
    stim.push_back(px(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
    stim.push_back(px(1'b1, 1'b0, 1'b0, 8'd255, 8'd0, 8'd0));
    stim.push_back(px(1'b1, 1'b0, 1'b0, 8'd255, 8'd0, 8'd0));
    stim.push_back(px(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
    run_stim();
    for (int i = 0; i < 9; i++) begin
      tests_run++;
      if (obs_d[i+LAT] !== want[i] || obs_de[i+LAT] !== stim[i].de) begin
        tests_failed++;
        $display("FAIL color[%0d]: got de=%b d=%h want de=%b d=%h",
                 i, obs_de[i+LAT], obs_d[i+LAT], stim[i].de, want[i]);
      end
    end
  endtask

  task automatic test_alignment();
    int de_cnt, first;
    stim.delete();
    for (int i = 0; i < 20; i++)
      stim.push_back(px(1'b0, (i >= 4 && i < 12), (i < 8), 8'd0, 8'd0, 8'd0));
    for (int i = 0; i < 1280; i++)
      stim.push_back(px(1'b1, 1'b0, (i == 700), rnd_c(), rnd_c(), rnd_c()));
    for (int i = 0; i < 10; i++)
      stim.push_back(px(1'b0, (i >= 3), 1'b1, 8'd0, 8'd0, 8'd0));
    run_stim();
    de_cnt = 0;
    first = -1;
    for (int i = 0; i < obs_de.size(); i++) begin
      if (obs_de[i] === 1'b1) begin
        de_cnt++;
        if (first < 0) first = i;
      end
    end
    tests_run += 2;
    if (de_cnt != 1280) begin
      tests_failed++; $display("FAIL align_de_len: got %0d want 1280", de_cnt);
    end
    if (first != 20 + LAT) begin
      tests_failed++; $display("FAIL align_de_start: got %0d want %0d", first, 20 + LAT);
    end
    for (int i = 0; i < stim.size(); i++) begin
      tests_run += 2;
      if ({obs_de[i+LAT], obs_hs[i+LAT], obs_vs[i+LAT]} !== {stim[i].de, stim[i].hs, stim[i].vs})
      begin
        tests_failed++;
        $display("FAIL align_sync[%0d]: got de/hs/vs=%b%b%b want %b%b%b", i,
                 obs_de[i+LAT], obs_hs[i+LAT], obs_vs[i+LAT], stim[i].de, stim[i].hs, stim[i].vs);
      end
      if (obs_d[i+LAT] !== exp_d[i]) begin
        tests_failed++;
        $display("FAIL align_data[%0d]: got %h want %h", i, obs_d[i+LAT], exp_d[i]);
      end
    end
  endtask

  task automatic test_phase_reset();
    int y, cb, cr;
    stim.delete();
    stim.push_back(px(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
    stim.push_back(px(1'b1, 1'b0, 1'b0, 8'd255, 8'd0, 8'd0));
    stim.push_back(px(1'b1, 1'b0, 1'b0, 8'd0, 8'd255, 8'd0));
    stim.push_back(px(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd255));
    for (int i = 0; i < 4; i++) stim.push_back(px(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0));
    stim.push_back(px(1'b1, 1'b0, 1'b0, 8'd255, 8'd0, 8'd0));
    stim.push_back(px(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd255));
    stim.push_back(px(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
    run_stim();
    for (int i = 0; i < stim.size(); i++) begin
      tests_run++;
      if (obs_d[i+LAT] !== exp_d[i]) begin
        tests_failed++;
        $display("FAIL phase[%0d]: got %h want %h", i, obs_d[i+LAT], exp_d[i]);
      end
    end
    // The third (lone) pixel carries its own unaveraged Cb.
    ycc(stim[3], y, cb, cr);
    tests_run++;
    if (obs_d[3+LAT] !== {8'(y), 8'(cb)}) begin
      tests_failed++;
      $display("FAIL phase_lone: got %h want %h", obs_d[3+LAT], {8'(y), 8'(cb)});
    end
  endtask

`ifdef HDMI_CHROMA_AVG_EN
  task automatic test_avg();
    int first;
    stim.delete();
    stim.push_back(px(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
    stim.push_back(px(1'b1, 1'b0, 1'b0, 8'd255, 8'd0, 8'd0));
    stim.push_back(px(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd255));
    stim.push_back(px(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
    run_stim();
    first = -1;
    for (int i = 0; i < obs_de.size(); i++)
      if (first < 0 && obs_de[i] === 1'b1) first = i;
    tests_run += 3;
    if (first != 1 + 5) begin
      tests_failed++; $display("FAIL avg_latency: got %0d want %0d", first - 1, 5);
    end
    if (obs_d[6] !== 16'h52A5) begin
      tests_failed++; $display("FAIL avg_cb: got %h want 52a5", obs_d[6]);
    end
    if (obs_d[7] !== 16'h29AF) begin
      tests_failed++; $display("FAIL avg_cr: got %h want 29af", obs_d[7]);
    end
  endtask
`endif

  task automatic test_random();
    int n, run, gap;
    logic [7:0] yb, cbyte;
    stim.delete();
    n = 0;
    while (n < 10000) begin
      gap = $urandom_range(0, 6);
      for (int i = 0; i < gap; i++)
        stim.push_back(px(1'b0, (i < 2), 1'($urandom_range(0, 1)), 8'd0, 8'd0, 8'd0));
      run = $urandom_range(1, 64);
      for (int i = 0; i < run; i++)
        stim.push_back(px(1'b1, 1'b0, 1'b0, rnd_c(), rnd_c(), rnd_c()));
      n += run;
    end
    run_stim();
    for (int i = 0; i < stim.size(); i++) begin
      tests_run++;
      if (obs_d[i+LAT] !== exp_d[i] || obs_de[i+LAT] !== stim[i].de) begin
        tests_failed++;
        $display("FAIL rand[%0d]: got de=%b d=%h want de=%b d=%h", i,
                 obs_de[i+LAT], obs_d[i+LAT], stim[i].de, exp_d[i]);
      end
      if (stim[i].de) begin
        yb = obs_d[i+LAT][15:8];
        cbyte = obs_d[i+LAT][7:0];
        tests_run++;
        if (yb < 8'd16 || yb > 8'd235 || cbyte < 8'd16 || cbyte > 8'd240) begin
          tests_failed++;
          $display("FAIL rand_range[%0d]: got Y=%0d C=%0d want Y 16..235 C 16..240",
                   i, yb, cbyte);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_colors();
    test_alignment();
    test_phase_reset();
`ifdef HDMI_CHROMA_AVG_EN
    test_avg();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hdmi_ycbcr422_packer.md
Name: hdmi_ycbcr422_packer

Overview:
- Pixel-path stage directly upstream of the ADV7511 output pins in hdmi_display.
- Takes 24-bit RGB plus DE/HS/VS from the 720p timing/pattern source.
- Converts to BT.601 limited-range YCbCr, decimates chroma to 4:2:2, and drives hdmi_d[15:0], hdmi_de, hdmi_hsync and hdmi_vsync with syncs delay-matched to the data.
- Runs entirely in the pixel clock domain (74.25 MHz for 720p).

Parameters:
- COLOR_W, 8, bits per input colour component; also the width of the Y and C output bytes.
- BLANK_Y, 8'h10, Y byte driven while DE=0.
- BLANK_C, 8'h80, C byte driven while DE=0.
- CB_FIRST, 1, 1: even pixel carries Cb and odd carries Cr; 0: swapped.

Ports:
- clk_pix  in  1  pixel clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronised outside this block.
- vid_de  in  1  active video.
- vid_hs  in  1  hsync, passed through unmodified (polarity preserved).
- vid_vs  in  1  vsync, passed through unmodified.
- vid_r  in  COLOR_W  red.
- vid_g  in  COLOR_W  green.
- vid_b  in  COLOR_W  blue.
- hdmi_d  out  16  [15:8] = Y, [7:0] = Cb or Cr.
- hdmi_de  out  1  delayed vid_de.
- hdmi_hsync  out  1  delayed vid_hs.
- hdmi_vsync  out  1  delayed vid_vs.

Behaviour:
- Reset (async, rst_n=0):
  - hdmi_d = {BLANK_Y, BLANK_C}; hdmi_de, hdmi_hsync and hdmi_vsync = 0.
  - All pipeline registers are cleared to their blank/0 equivalents and the pixel phase is set to 0.
  - Reset mid-line discards all in-flight pixels; the first DE after reset starts at phase 0.
- Colour matrix (signed arithmetic, 18-bit intermediates, round by +128 then arithmetic >>8):
  - Y  = 16  + ((66R + 129G + 25B + 128) >>> 8)
  - Cb = 128 + ((-38R - 74G + 112B + 128) >>> 8)
  - Cr = 128 + ((112R - 94G - 18B + 128) >>> 8)
  - Clamp Y to [16,235] and C to [16,240].
- Pipeline:
  - S1: products.
  - S2: sums.
  - S3: round, offset, clamp.
  - S4: chroma select and output register.
  - Latency LAT = 4 clk_pix cycles from vid_* to hdmi_*.
  - vid_de/hs/vs travel through an LAT-deep shift register, so all outputs stay cycle-aligned.
- 4:2:2 phase:
  - Toggles on every S3 cycle with DE=1; forced to 0 on every cycle with DE=0, so each line restarts at even phase.
  - Even pixel: hdmi_d = {Y0, C_a}. Odd pixel: hdmi_d = {Y1, C_b}. C_a/C_b = Cb/Cr when CB_FIRST=1.
  - Without averaging, both chroma samples are co-sited with the even pixel: the even pixel's second chroma value is held one cycle for the odd slot.
- Odd-length line (DE falls after an even pixel): the lone pixel outputs its own C_a; no C_b slot is emitted.
- DE=0 at S4: hdmi_d = {BLANK_Y, BLANK_C}, regardless of pipeline contents.
- Continuous operation, no back-pressure; one pixel in, one pixel out, every cycle.

Optional Feature:
- Macro: HDMI_CHROMA_AVG_EN.
- Defined:
  - Chroma for each pair = (C_pix0 + C_pix1 + 1) >> 1 for both Cb and Cr.
  - Adds one pipeline stage, so LAT = 5; syncs are delayed to match.
  - Odd-length-line lone pixel uses its unaveraged chroma.
- Undefined: co-sited decimation as above, LAT = 4.

Decomposition:
- Shared include hdmi_video_defs.vh holds:
  - the matrix coefficients (66/129/25, -38/-74/112, 112/-94/-18);
  - the clamp limits 16/235/240;
  - the blank values;
  - LAT as a macro-dependent constant.
- One sub-module, rgb2ycbcr_mac: S1–S3 matrix/round/clamp, 3-cycle latency, no control logic.
- Top level owns the phase counter, chroma select/averaging, sync delay line and blanking mux.

Test Plan:
- Reset: rst_n=0 mid-line at 0x123 → all outputs immediately 0, hdmi_d=16'h1080. After release, the first DE pixel emerges at LAT with even phase.
- Colour values: white 255/255/255 → hdmi_d = 16'hEB80 then 16'hEB80. Black → 16'h1080. Pure red 255/0/0 → Y=82, Cb=90, Cr=240, i.e. 16'h525A then 16'h52F0.
- Alignment: 1280-pixel DE burst with hs/vs toggles → hdmi_de high for exactly 1280 cycles starting LAT cycles later; hdmi_hsync/vsync edges shifted by exactly LAT.
- Phase reset: 3-pixel DE burst (red, green, blue) followed by gap, then a new line → outputs Cb, Cr, Cb; the next line starts with Cb again.
- Averaging (HDMI_CHROMA_AVG_EN): pixel pair red then blue → Cb = (90+240+1)>>1 = 165, Cr = (240+110+1)>>1 = 175; latency measured as 5.
- Clamp: random RGB sweep of 10k pixels checked against a reference model → Y always in [16,235] and C always in [16,240].
